gates_seq_ctrl: RTL

//   Input sequencer for the 2-input logic-gate LED demo. Drives the gate block's a/b inputs.

---
 rtl/gates_seq_ctrl_if.sv | 33 +++
 rtl/gates_seq_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gates_seq_ctrl_if.sv
// Board-side bundle for the gate-demo input sequencer: raw switches and keys
// going in, gate inputs and mode LEDs coming out.
interface gates_seq_ctrl_if;
  logic       sw_a;
  logic       sw_b;
  logic       key_mode;
  logic       key_step;
  logic       a;
  logic       b;
  logic [1:0] mode_led;

  // Board / stimulus side: drives the raw inputs, watches the gate inputs and LEDs.
  modport master (
    output sw_a,
    output sw_b,
    output key_mode,
    output key_step,
    input  a,
    input  b,
    input  mode_led
  );

  // Sequencer side.
  modport slave (
    input  sw_a,
    input  sw_b,
    input  key_mode,
    input  key_step,
    output a,
    output b,
    output mode_led
  );
endinterface

// File: rtl/gates_seq_ctrl.sv
// Input sequencer for the 2-input logic-gate LED demo.
// MANUAL: switches drive a/b. AUTO: a/b walk 00..11 on a dwell timer.
// STEP: a/b advance once per debounced key_step press. key_mode cycles
// MANUAL -> AUTO -> STEP -> MANUAL. Current mode shown on two active-low LEDs.
module gates_seq_ctrl #(
  parameter int DEB_CYC   = 240000,
  parameter int DWELL_CYC = 12000000
) (
  input  logic          clk,
  input  logic          rst_n,
  gates_seq_ctrl_if.slave bus
);

  // Counter widths sized so the terminal value always fits, even for 1.
  localparam int DEB_W   = $clog2(DEB_CYC + 1);
  localparam int DWELL_W = $clog2(DWELL_CYC + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_CYC - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);

  // Active-low LED encodings: bit 0 lit in AUTO, bit 1 lit in STEP.
  localparam logic [1:0] LED_MANUAL = 2'b11;
  localparam logic [1:0] LED_AUTO   = 2'b10;
  localparam logic [1:0] LED_STEP   = 2'b01;

  // Synchronizer lane order: {key_step, key_mode, sw_b, sw_a}.
  // Keys idle high (released), so their flops reset high to avoid a
  // phantom press right after reset release.
  localparam logic [3:0] SYNC_RST = 4'b1100;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_AUTO   = 2'd1,
    MODE_STEP   = 2'd2
  } mode_t;

  logic [3:0] raw_in;
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;

  logic       sw_a_sync;
  logic       sw_b_sync;
  logic [1:0] key_sync;    // [0] key_mode, [1] key_step
  logic [1:0] key_press;   // one-cycle press pulses, same lane order

  mode_t                mode_reg;
  logic [1:0]           pattern_reg;
  logic [1:0]           pattern_inc;
  logic [DWELL_W-1:0]   dwell_cnt_reg;
  logic                 a_reg;
  logic                 b_reg;
  logic [1:0]           mode_led_reg;

  assign raw_in = {bus.key_step, bus.key_mode, bus.sw_b, bus.sw_a};

  // Two-flop synchronizer for every raw board input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= SYNC_RST;
      sync2_reg <= SYNC_RST;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign sw_a_sync = sync2_reg[0];
  assign sw_b_sync = sync2_reg[1];
  assign key_sync  = sync2_reg[3:2];

  // One debouncer per key. A new level is accepted only after it has been
  // seen for DEB_CYC consecutive cycles; a 1->0 acceptance is a press.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_reg;
      logic             level_reg;
      logic             press_reg;

      // Count cycles of disagreement between sync and debounced level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          level_reg <= 1'b1;
          press_reg <= 1'b0;
        end else begin
          press_reg <= 1'b0;
          if (key_sync[gi] == level_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            level_reg <= key_sync[gi];
            cnt_reg   <= '0;
            press_reg <= ~key_sync[gi];
          end else begin
            cnt_reg <= cnt_reg + DEB_W'(1);
          end
        end
      end

      assign key_press[gi] = press_reg;
    end
  endgenerate

  assign pattern_inc = pattern_reg + 2'd1;

  // Mode FSM with registered a/b and LEDs. A mode press takes priority over
  // both the AUTO terminal-count increment and a same-cycle step press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg      <= MODE_MANUAL;
      pattern_reg   <= 2'b00;
      dwell_cnt_reg <= '0;
      a_reg         <= 1'b0;
      b_reg         <= 1'b0;
      mode_led_reg  <= LED_MANUAL;
    end else if (key_press[0]) begin
      dwell_cnt_reg <= '0;
      case (mode_reg)
        MODE_MANUAL: begin
          // Seed the walk from what the gate currently sees: no visible jump.
          mode_reg     <= MODE_AUTO;
          pattern_reg  <= {a_reg, b_reg};
          mode_led_reg <= LED_AUTO;
        end
        MODE_AUTO: begin
          mode_reg     <= MODE_STEP;
          mode_led_reg <= LED_STEP;
        end
        MODE_STEP: begin
          // a/b hold this cycle and pick up the switches from the next one.
          mode_reg     <= MODE_MANUAL;
          mode_led_reg <= LED_MANUAL;
        end
        default: begin
          mode_reg     <= MODE_MANUAL;
          mode_led_reg <= LED_MANUAL;
        end
      endcase
    end else begin
      case (mode_reg)
        MODE_MANUAL: begin
          a_reg         <= sw_a_sync;
          b_reg         <= sw_b_sync;
          dwell_cnt_reg <= '0;
        end
        MODE_AUTO: begin
          if (dwell_cnt_reg == DWELL_LAST) begin
            dwell_cnt_reg  <= '0;
            pattern_reg    <= pattern_inc;
            {a_reg, b_reg} <= pattern_inc;
          end else begin
            dwell_cnt_reg <= dwell_cnt_reg + DWELL_W'(1);
          end
        end
        MODE_STEP: begin
          dwell_cnt_reg <= '0;
          if (key_press[1]) begin
            pattern_reg    <= pattern_inc;
            {a_reg, b_reg} <= pattern_inc;
          end
        end
        default: begin
          mode_reg     <= MODE_MANUAL;
          mode_led_reg <= LED_MANUAL;
        end
      endcase
    end
  end

  assign bus.a        = a_reg;
  assign bus.b        = b_reg;
  assign bus.mode_led = mode_led_reg;

endmodule
